// File: rtl/trace_buffer_reader.sv
// Read-side controller for the circular trace buffer: freezes tracing, walks every
// valid entry oldest-first and serializes each N-lane vector onto a valid/ready stream.
module trace_buffer_reader #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TB_SIZE    = 64,
   parameter int RD_LATENCY = 1
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         dump_start,
   input  logic [$clog2(TB_SIZE)-1:0]   wr_ptr,
   input  logic                         wrapped,
   output logic                         tracing,
   output logic [$clog2(TB_SIZE)-1:0]   tb_mem_address,
   input  logic [N*DATA_WIDTH-1:0]      tb_vector_in,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         dump_busy,
   output logic                         dump_done
);
   localparam int AW = $clog2(TB_SIZE);
   localparam int CW = $clog2(TB_SIZE + 1);
   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam int WW = $clog2(RD_LATENCY + 1);
   localparam int VW = N * DATA_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FREEZE = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_SEND   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   state_t        state_r, state_s;
   logic [AW-1:0] addr_r, addr_s, start_s, addr_inc_s;
   logic [CW-1:0] remain_r, remain_s, count_s;
   logic [LW-1:0] lane_r, lane_s;
   logic [WW-1:0] wait_r, wait_s;
   logic [VW-1:0] shreg_r, shreg_s;
   logic          out_valid_r, out_last_r, tracing_r, busy_r, done_r;
   logic          handshake_s;

   // Oldest entry and entry count as seen by the write side right now
   assign start_s     = wrapped ? wr_ptr : {AW{1'b0}};
   assign count_s     = wrapped ? CW'(TB_SIZE) : CW'(wr_ptr);
   // Explicit wrap so non-power-of-two depths never address past the end
   assign addr_inc_s  = (addr_r == AW'(TB_SIZE - 1)) ? {AW{1'b0}} : addr_r + AW'(1);
   assign handshake_s = out_valid_r & out_ready;

   // Next-state and datapath update for the dump sequencer
   always_comb begin
      state_s  = state_r;
      addr_s   = addr_r;
      remain_s = remain_r;
      lane_s   = lane_r;
      wait_s   = wait_r;
      shreg_s  = shreg_r;
      case (state_r)
         ST_IDLE: begin
            if (dump_start) begin
               state_s  = ST_FREEZE;
               addr_s   = start_s;
               remain_s = count_s;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_FREEZE: begin
            // Re-sample after the last in-flight write has landed
            addr_s   = start_s;
            remain_s = count_s;
            if (count_s == {CW{1'b0}}) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_ADDR;
            end
         end
         ST_ADDR: begin
            wait_s  = {WW{1'b0}};
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_r == WW'(RD_LATENCY - 1)) begin
               shreg_s = tb_vector_in;
               lane_s  = {LW{1'b0}};
               state_s = ST_SEND;
            end else begin
               wait_s  = wait_r + WW'(1);
            end
         end
         ST_SEND: begin
            if (handshake_s) begin
               shreg_s = shreg_r >> DATA_WIDTH;
               if (lane_r == LW'(N - 1)) begin
                  if (remain_r == CW'(1)) begin
                     state_s = ST_DONE;
                  end else begin
                     remain_s = remain_r - CW'(1);
                     addr_s   = addr_inc_s;
                     state_s  = ST_ADDR;
                  end
               end else begin
                  lane_s = lane_r + LW'(1);
               end
            end else begin
               state_s = ST_SEND;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs (outputs decoded from next state)
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r     <= ST_IDLE;
         addr_r      <= {AW{1'b0}};
         remain_r    <= {CW{1'b0}};
         lane_r      <= {LW{1'b0}};
         wait_r      <= {WW{1'b0}};
         shreg_r     <= {VW{1'b0}};
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         tracing_r   <= 1'b1;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         addr_r      <= addr_s;
         remain_r    <= remain_s;
         lane_r      <= lane_s;
         wait_r      <= wait_s;
         shreg_r     <= shreg_s;
         out_valid_r <= (state_s == ST_SEND);
         out_last_r  <= (state_s == ST_SEND) && (lane_s == LW'(N - 1)) && (remain_s == CW'(1));
         tracing_r   <= (state_s == ST_IDLE) || (state_s == ST_DONE);
         busy_r      <= (state_s != ST_IDLE) && (state_s != ST_DONE);
         done_r      <= (state_s == ST_DONE);
      end
   end

   assign tracing        = tracing_r;
   assign tb_mem_address = addr_r;
   assign out_data       = shreg_r[DATA_WIDTH-1:0];
   assign out_valid      = out_valid_r;
   assign out_last       = out_last_r;
   assign dump_busy      = busy_r;
   assign dump_done      = done_r;

endmodule

// File: doc/trace_buffer_reader.md
Name: trace_buffer_reader

Overview:
- Read-side controller for the circular trace buffer; drains its contents to the host.
- On a dump command it stops tracing and reads every valid entry through the buffer's read port, oldest first.
- Each N-lane vector is serialized into a DATA_WIDTH-wide valid/ready stream for the host-side link.
- Sits between the trace buffer's read port (address out, vector in) and the debug host interface.

Parameters:
N, 8, lanes per trace-buffer entry
DATA_WIDTH, 32, bits per lane and per output word
TB_SIZE, 64, trace-buffer depth in entries; need not be a power of two
RD_LATENCY, 1, cycles from tb_mem_address change to matching tb_vector_in

Ports:
clk  in  1  clock; all logic on rising edge
resetn  in  1  synchronous active-low reset
dump_start  in  1  one-cycle request to dump; ignored unless IDLE
wr_ptr  in  $clog2(TB_SIZE)  buffer's next write address
wrapped  in  1  sticky; buffer has written at least TB_SIZE entries
tracing  out  1  enable to trace buffer; low while dumping
tb_mem_address  out  $clog2(TB_SIZE)  read address to buffer port B
tb_vector_in  in  N x DATA_WIDTH  read data from buffer port B
out_data  out  DATA_WIDTH  serialized lane word
out_valid  out  1  out_data valid
out_ready  in  1  host accepts word when out_valid & out_ready
out_last  out  1  marks final word of the dump
dump_busy  out  1  high from accepted dump_start until DONE
dump_done  out  1  one-cycle pulse at end of dump

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE; tracing=1; tb_mem_address=0; out_valid=0; out_last=0; out_data=0; dump_busy=0; dump_done=0; entry/lane counters cleared.
- Reset mid-dump: abort immediately. Any partially sent entry is discarded; the host sees no out_last.
- States: IDLE, FREEZE, ADDR, WAIT, SEND, DONE.
- IDLE:
  - tracing=1.
  - dump_start=1 -> FREEZE, dump_busy=1, tracing=0.
  - Latch start = wrapped ? wr_ptr : 0.
  - Latch count = wrapped ? TB_SIZE : wr_ptr.
- FREEZE:
  - One cycle, so an in-flight write lands first.
  - Re-sample wr_ptr/wrapped and recompute start/count from them.
  - count==0 -> DONE; else -> ADDR.
- ADDR: drive tb_mem_address=current address -> WAIT.
- WAIT:
  - Hold the address for RD_LATENCY cycles.
  - Then capture all N lanes of tb_vector_in into a shift register -> SEND, lane=0.
- SEND:
  - out_valid=1; out_data = captured lane[lane] (lane 0 first).
  - On handshake, lane increments.
  - After lane N-1 is accepted:
    - entries remaining -> address advances, back to ADDR;
    - otherwise -> DONE.
- Address advance: addr==TB_SIZE-1 ? 0 : addr+1. Never compute it modulo a power of two.
- out_last=1 only with the lane N-1 word of the final entry.
- Stream rules:
  - Once out_valid=1, out_data/out_last hold stable until the handshake.
  - out_valid never drops without a handshake.
  - out_ready=1 while out_valid=0 has no effect.
- Throughput: each entry costs 1 (ADDR) + RD_LATENCY (WAIT) + N handshake cycles. No prefetch is required.
- DONE: dump_done=1 for one cycle; dump_busy=0; tracing=1 -> IDLE.
- Total words = count*N.
- dump_start during any non-IDLE state is ignored, with no queueing.
- Counters are sized to hold TB_SIZE inclusive, i.e. $clog2(TB_SIZE+1) bits.

Test Plan:
- N=8, TB_SIZE=64, wrapped=0, wr_ptr=3 holding entries v0..v2; dump_start with out_ready=1 -> exactly 24 words, addresses 0,1,2, lane order 0..7, out_last on word 24, dump_done one cycle later, tracing low throughout.
- wrapped=1, wr_ptr=10 -> addresses 10..63 then 0..9 (64 entries, 512 words), oldest data first, out_last on word 512.
- TB_SIZE=48 (non-power-of-two), wrapped=1, wr_ptr=47 -> addresses 47, 0, 1, ..., 46; address never reaches 48.
- Random out_ready backpressure (~50% duty) -> out_data/out_last stable while stalled, no word dropped or duplicated, word sequence identical to the no-backpressure run.
- wrapped=0, wr_ptr=0 -> no out_valid; dump_done asserted 2 cycles after dump_start; tracing restored.
- Assert resetn=0 for one cycle mid-SEND, then a second dump_start -> outputs at reset values after the reset edge; the second dump restarts from the oldest entry and completes normally. A dump_start pulsed while busy produces no extra dump.
